// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer priority mux with registered output and border-flash sequencer.
// Define BORDER_FLASH_EN to build the flash FSM; otherwise it is a plain priority mux.
module draw_layer_arbiter #(
  parameter int         FLASH_FRAMES  = 8,
  parameter int         FLASH_TOGGLES = 6,
  parameter logic [7:0] ALERT_COLOR   = 8'hE0
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       foulPulse,
  input  logic       drawingRequestCue,
  input  logic [7:0] RGBCue,
  input  logic       drawingRequestBalls,
  input  logic [7:0] RGBBalls,
  input  logic       drawingRequestBorders,
  input  logic [7:0] RGBBorders,
  input  logic [7:0] RGBBackground,
  output logic [7:0] RGBOut,
  output logic       flashBusy
);

  logic       flash_on;
  logic [7:0] rgb_nxt;

`ifdef BORDER_FLASH_EN
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  localparam logic [7:0] F_LAST = 8'(FLASH_FRAMES - 1);
  localparam logic [3:0] T_LAST = 4'(FLASH_TOGGLES - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] frameCnt, frame_nxt;
  logic [3:0] toggleCnt, tog_nxt;

  // A foul always wins over a coincident frame pulse.
  always_comb begin
    state_nxt = state;
    frame_nxt = frameCnt;
    tog_nxt   = toggleCnt;
    if (foulPulse) begin
      state_nxt = ON;
      frame_nxt = '0;
      tog_nxt   = '0;
    end else if (state != IDLE && startOfFrame) begin
      if (frameCnt == F_LAST) begin
        frame_nxt = '0;
        if (toggleCnt == T_LAST) begin
          state_nxt = IDLE;
        end else begin
          tog_nxt   = toggleCnt + 4'd1;
          state_nxt = (state == ON) ? OFF : ON;
        end
      end else begin
        frame_nxt = frameCnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      frameCnt  <= '0;
      toggleCnt <= '0;
      flashBusy <= 1'b0;
    end else begin
      state     <= state_nxt;
      frameCnt  <= frame_nxt;
      toggleCnt <= tog_nxt;
      flashBusy <= (state_nxt != IDLE);
    end
  end

  assign flash_on = (state == ON);
`else
  logic unused_flash;
  assign unused_flash = ^{startOfFrame, foulPulse};
  assign flash_on     = 1'b0;
  assign flashBusy    = 1'b0;
`endif

  always_comb begin
    rgb_nxt = RGBBackground;
    if (drawingRequestCue) begin
      rgb_nxt = RGBCue;
    end else if (drawingRequestBalls) begin
      rgb_nxt = RGBBalls;
    end else if (drawingRequestBorders) begin
      rgb_nxt = flash_on ? ALERT_COLOR : RGBBorders;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut <= 8'h00;
    end else begin
      RGBOut <= rgb_nxt;
    end
  end

endmodule
